// File: rtl/brc_pkg.sv
// Shared types and sizing helpers for the sequential branch-compare unit.
package brc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } brc_state_e;

  function automatic int unsigned brc_nchunk(input int unsigned data_size,
                                             input int unsigned chunk);
    return data_size / chunk;
  endfunction

  // Chunk index width, never narrower than one bit.
  function automatic int unsigned brc_idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/brc_seq_unit_cmp.sv
// Recursive unsigned magnitude comparator: splits the operands in halves
// and merges the equal/less results of the upper and lower parts.
module brc_seq_unit_cmp #(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic [DATA_SIZE-1:0] i_a,
  input  logic [DATA_SIZE-1:0] i_b,
  output logic                 o_equal,
  output logic                 o_less
);

  if (DATA_SIZE == 1) begin : g_leaf
    assign o_equal = (i_a == i_b);
    assign o_less  = ~i_a[0] & i_b[0];
  end else begin : g_split
    localparam int unsigned LO_W = DATA_SIZE / 2;
    localparam int unsigned HI_W = DATA_SIZE - LO_W;

    logic hi_equal;
    logic hi_less;
    logic lo_equal;
    logic lo_less;

    brc_seq_unit_cmp #(.DATA_SIZE(HI_W)) u_hi (
      .i_a     (i_a[DATA_SIZE-1:LO_W]),
      .i_b     (i_b[DATA_SIZE-1:LO_W]),
      .o_equal (hi_equal),
      .o_less  (hi_less)
    );

    brc_seq_unit_cmp #(.DATA_SIZE(LO_W)) u_lo (
      .i_a     (i_a[LO_W-1:0]),
      .i_b     (i_b[LO_W-1:0]),
      .o_equal (lo_equal),
      .o_less  (lo_less)
    );

    assign o_equal = hi_equal & lo_equal;
    assign o_less  = hi_less | (hi_equal & lo_less);
  end

endmodule

// File: rtl/brc_seq_unit.sv
// Multi-cycle branch comparator: walks the operands MSB chunk first through
// one shared CHUNK-wide comparator and stops at the first unequal chunk.
module brc_seq_unit
  import brc_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned CHUNK     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [DATA_SIZE-1:0] i_rs1_data,
  input  logic [DATA_SIZE-1:0] i_rs2_data,
  input  logic                 i_br_un,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_brc_equal,
  output logic                 o_brc_less,
  output logic                 o_busy
);

  localparam int unsigned NCHUNK = brc_nchunk(DATA_SIZE, CHUNK);
  localparam int unsigned IDX_W  = brc_idx_w(NCHUNK);

  if ((CHUNK == 0) || ((CHUNK & (CHUNK - 1)) != 0) || ((DATA_SIZE % CHUNK) != 0)) begin : g_bad_cfg
    $fatal(1, "brc_seq_unit: CHUNK must be a power of 2 dividing DATA_SIZE");
  end

  brc_state_e                        state;
  logic [IDX_W-1:0]                  idx;
  logic [NCHUNK-1:0][CHUNK-1:0]      rs1_q;
  logic [NCHUNK-1:0][CHUNK-1:0]      rs2_q;
  logic [CHUNK-1:0]                  chunk_a;
  logic [CHUNK-1:0]                  chunk_b;
  logic                              chunk_equal;
  logic                              chunk_less;
  logic [DATA_SIZE-1:0]              sign_flip;

  assign o_req_ready = (state == IDLE);

  // Flipping both MSBs maps signed order onto unsigned order.
  assign sign_flip = {~i_br_un, {(DATA_SIZE-1){1'b0}}};

  always_comb begin
    chunk_a = rs1_q[idx];
    chunk_b = rs2_q[idx];
  end

  brc_seq_unit_cmp #(.DATA_SIZE(CHUNK)) u_cmp (
    .i_a     (chunk_a),
    .i_b     (chunk_b),
    .o_equal (chunk_equal),
    .o_less  (chunk_less)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      o_rsp_valid <= 1'b0;
      o_brc_equal <= 1'b0;
      o_brc_less  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            rs1_q  <= i_rs1_data ^ sign_flip;
            rs2_q  <= i_rs2_data ^ sign_flip;
            idx    <= IDX_W'(NCHUNK - 1);
            state  <= CMP;
            o_busy <= 1'b1;
          end
        end
        CMP: begin
          if (!chunk_equal) begin
            o_brc_equal <= 1'b0;
            o_brc_less  <= chunk_less;
            o_rsp_valid <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            o_brc_equal <= 1'b1;
            o_brc_less  <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brc_seq_unit.sv
// Directed bench for brc_seq_unit (DATA_SIZE=32, CHUNK=8).
module tb_brc_seq_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_br_un;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_brc_equal;
  logic        o_brc_less;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  brc_seq_unit #(.DATA_SIZE(32), .CHUNK(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .i_br_un     (i_br_un),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_brc_equal (o_brc_equal),
    .o_brc_less  (o_brc_less),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        un;
    logic        exp_eq;
    logic        exp_less;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request, wait (bounded) for the response, check it, then drain.
  task automatic run_req(input logic [31:0] rs1, input logic [31:0] rs2, input logic un,
                         input logic exp_eq, input logic exp_less, input int exp_lat,
                         input string tag);
    int lat;
    chk({tag, "_ready_before"}, 32'(o_req_ready), 32'd1);
    i_rs1_data  = rs1;
    i_rs2_data  = rs2;
    i_br_un     = un;
    i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    i_rs1_data  = ~rs1;
    i_rs2_data  = ~rs2;
    i_br_un     = ~un;
    chk({tag, "_busy_accept"}, 32'(o_busy), 32'd1);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (o_rsp_valid) begin
        lat = c;
        break;
      end
      chk({tag, "_busy_cmp"}, 32'(o_busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_equal"}, 32'(o_brc_equal), 32'(exp_eq));
    chk({tag, "_less"}, 32'(o_brc_less), 32'(exp_less));
    chk({tag, "_ready_done"}, 32'(o_req_ready), 32'd0);
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(o_req_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h12345678, 32'h92345678, 1'b1, 1'b0, 1'b1, 1};
    vecs[1] = '{32'h12345678, 32'h92345678, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[7] = '{32'h00001200, 32'h00001300, 1'b0, 1'b0, 1'b1, 3};
    vecs[8] = '{32'h00000005, 32'h00000003, 1'b1, 1'b0, 1'b0, 4};
    vecs[9] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 4};

    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_rs1_data  = '0;
    i_rs2_data  = '0;
    i_br_un     = 1'b0;
    i_rsp_ready = 1'b0;
    repeat (3) step();
    i_rst_n = 1'b1;
    step();
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_equal", 32'(o_brc_equal), 32'd0);
    chk("rst_less", 32'(o_brc_less), 32'd0);

    for (int v = 0; v < 10; v++) begin
      run_req(vecs[v].rs1, vecs[v].rs2, vecs[v].un, vecs[v].exp_eq, vecs[v].exp_less,
              vecs[v].exp_lat, $sformatf("vec%0d", v));
    end

    // Stalled consumer: result must hold until i_rsp_ready.
    i_rs1_data  = 32'h00000100;
    i_rs2_data  = 32'h00000101;
    i_br_un     = 1'b1;
    i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (o_rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk("stall_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(o_rsp_valid), 32'd1);
      chk("stall_less", 32'(o_brc_less), 32'd1);
      chk("stall_equal", 32'(o_brc_equal), 32'd0);
      chk("stall_ready", 32'(o_req_ready), 32'd0);
      i_req_valid = 1'b1;
      step();
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    chk("stall_release_valid", 32'(o_rsp_valid), 32'd0);
    chk("stall_release_ready", 32'(o_req_ready), 32'd1);

    // Reset in the second CMP cycle of an equal-operand request.
    i_rs1_data  = 32'hCAFEF00D;
    i_rs2_data  = 32'hCAFEF00D;
    i_br_un     = 1'b1;
    i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    step();
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_rsp_valid), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_ready", 32'(o_req_ready), 32'd1);
    step();
    #3;
    i_rst_n = 1'b1;
    step();
    chk("postrst_valid", 32'(o_rsp_valid), 32'd0);
    run_req(32'h00000005, 32'h00000003, 1'b1, 1'b0, 1'b0, 4, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
